// File: rtl/oled_frame_streamer.sv
// SPI master for a 128x64 SSD1306 OLED: panel reset, init command ROM, then an endless
// loop of address-window commands followed by a 1024-byte frame fetched from an external source.
module oled_frame_streamer #(
    parameter int CLK_DIV        = 2,
    parameter int RESET_CYCLES   = 27000,
    parameter int POWERUP_CYCLES = 27000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_to_send,
    output logic [9:0] byte_counter,
    output logic       oled_sclk,
    output logic       oled_mosi,
    output logic       oled_cs_n,
    output logic       oled_dc,
    output logic       oled_rst_n,
    output logic       init_done,
    output logic       frame_done
);
    localparam int WAIT_MAX = (RESET_CYCLES > POWERUP_CYCLES) ? RESET_CYCLES : POWERUP_CYCLES;
    localparam int WW       = $clog2(WAIT_MAX + 1);
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {S_PANEL_RST, S_POWERUP, S_INIT, S_ADDR, S_FRAME} state_t;
    typedef enum logic [1:0] {P_LOAD0, P_LOAD1, P_BITS} phase_t;

    state_t        state_reg, state_next;
    phase_t        phase_reg, phase_next;
    logic [WW-1:0] wait_cnt_reg, wait_cnt_next;
    logic [DW-1:0] div_cnt_reg, div_cnt_next;
    logic          half_reg, half_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [9:0]    idx_reg, idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          sclk_reg, sclk_next;
    logic          mosi_reg, mosi_next;
    logic          cs_n_reg, cs_n_next;
    logic          dc_reg, dc_next;
    logic          panel_rst_n_reg, panel_rst_n_next;
    logic [9:0]    byte_counter_reg, byte_counter_next;
    logic          init_done_reg, init_done_next;
    logic          frame_done_reg, frame_done_next;

    logic [4:0]    rom_addr;
    logic [7:0]    load_byte;
    logic [9:0]    last_idx;

    // Init sequence occupies entries 0..24, address window 25..30.
    function automatic logic [7:0] rom_lookup(input logic [4:0] a);
        case (a)
            5'd0:  rom_lookup = 8'hAE;  5'd1:  rom_lookup = 8'hD5;  5'd2:  rom_lookup = 8'h80;
            5'd3:  rom_lookup = 8'hA8;  5'd4:  rom_lookup = 8'h3F;  5'd5:  rom_lookup = 8'hD3;
            5'd6:  rom_lookup = 8'h00;  5'd7:  rom_lookup = 8'h40;  5'd8:  rom_lookup = 8'h8D;
            5'd9:  rom_lookup = 8'h14;  5'd10: rom_lookup = 8'h20;  5'd11: rom_lookup = 8'h00;
            5'd12: rom_lookup = 8'hA1;  5'd13: rom_lookup = 8'hC8;  5'd14: rom_lookup = 8'hDA;
            5'd15: rom_lookup = 8'h12;  5'd16: rom_lookup = 8'h81;  5'd17: rom_lookup = 8'hCF;
            5'd18: rom_lookup = 8'hD9;  5'd19: rom_lookup = 8'hF1;  5'd20: rom_lookup = 8'hDB;
            5'd21: rom_lookup = 8'h40;  5'd22: rom_lookup = 8'hA4;  5'd23: rom_lookup = 8'hA6;
            5'd24: rom_lookup = 8'hAF;  5'd25: rom_lookup = 8'h21;  5'd26: rom_lookup = 8'h00;
            5'd27: rom_lookup = 8'h7F;  5'd28: rom_lookup = 8'h22;  5'd29: rom_lookup = 8'h00;
            5'd30: rom_lookup = 8'h07;
            default: rom_lookup = 8'h00;
        endcase
    endfunction

    assign rom_addr = (state_reg == S_ADDR) ? (5'd25 + idx_reg[4:0]) : idx_reg[4:0];

    always_comb begin
        last_idx = 10'd1023;
        if (state_reg == S_INIT) last_idx = 10'd24;
        else if (state_reg == S_ADDR) last_idx = 10'd5;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_PANEL_RST;
            phase_reg        <= P_LOAD0;
            wait_cnt_reg     <= '0;
            div_cnt_reg      <= '0;
            half_reg         <= 1'b0;
            bit_cnt_reg      <= '0;
            idx_reg          <= '0;
            shift_reg        <= '0;
            sclk_reg         <= 1'b0;
            mosi_reg         <= 1'b0;
            cs_n_reg         <= 1'b1;
            dc_reg           <= 1'b0;
            panel_rst_n_reg  <= 1'b0;
            byte_counter_reg <= '0;
            init_done_reg    <= 1'b0;
            frame_done_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            phase_reg        <= phase_next;
            wait_cnt_reg     <= wait_cnt_next;
            div_cnt_reg      <= div_cnt_next;
            half_reg         <= half_next;
            bit_cnt_reg      <= bit_cnt_next;
            idx_reg          <= idx_next;
            shift_reg        <= shift_next;
            sclk_reg         <= sclk_next;
            mosi_reg         <= mosi_next;
            cs_n_reg         <= cs_n_next;
            dc_reg           <= dc_next;
            panel_rst_n_reg  <= panel_rst_n_next;
            byte_counter_reg <= byte_counter_next;
            init_done_reg    <= init_done_next;
            frame_done_reg   <= frame_done_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        phase_next        = phase_reg;
        wait_cnt_next     = wait_cnt_reg;
        div_cnt_next      = div_cnt_reg;
        half_next         = half_reg;
        bit_cnt_next      = bit_cnt_reg;
        idx_next          = idx_reg;
        shift_next        = shift_reg;
        sclk_next         = sclk_reg;
        mosi_next         = mosi_reg;
        cs_n_next         = cs_n_reg;
        dc_next           = dc_reg;
        panel_rst_n_next  = panel_rst_n_reg;
        byte_counter_next = byte_counter_reg;
        init_done_next    = init_done_reg;
        frame_done_next   = 1'b0;
        load_byte         = (state_reg == S_FRAME) ? data_to_send : rom_lookup(rom_addr);

        case (state_reg)
            S_PANEL_RST: begin
                if (wait_cnt_reg == WW'(RESET_CYCLES - 1)) begin
                    wait_cnt_next    = '0;
                    panel_rst_n_next = 1'b1;
                    state_next       = S_POWERUP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_POWERUP: begin
                if (wait_cnt_reg == WW'(POWERUP_CYCLES - 1)) begin
                    wait_cnt_next = '0;
                    cs_n_next     = 1'b0;
                    state_next    = S_INIT;
                    phase_next    = P_LOAD0;
                    idx_next      = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            default: begin
                case (phase_reg)
                    P_LOAD0: phase_next = P_LOAD1;
                    P_LOAD1: begin
                        // Source data has had one full clk to settle since byte_counter moved.
                        shift_next   = load_byte;
                        mosi_next    = load_byte[7];
                        phase_next   = P_BITS;
                        div_cnt_next = '0;
                        half_next    = 1'b0;
                        bit_cnt_next = '0;
                    end
                    default: begin
                        if (div_cnt_reg == DW'(CLK_DIV - 1)) begin
                            div_cnt_next = '0;
                            if (!half_reg) begin
                                sclk_next = 1'b1;
                                half_next = 1'b1;
                            end else begin
                                sclk_next = 1'b0;
                                half_next = 1'b0;
                                if (bit_cnt_reg == 3'd7) begin
                                    phase_next = P_LOAD0;
                                    if (idx_reg == last_idx) begin
                                        idx_next = '0;
                                        if (state_reg == S_INIT) begin
                                            state_next     = S_ADDR;
                                            init_done_next = 1'b1;
                                        end else if (state_reg == S_ADDR) begin
                                            state_next = S_FRAME;
                                        end else begin
                                            state_next      = S_ADDR;
                                            frame_done_next = 1'b1;
                                        end
                                    end else begin
                                        idx_next = idx_reg + 10'd1;
                                    end
                                    // byte_counter/dc settle as the next LOAD begins, giving the source its full latency.
                                    dc_next = (state_next == S_FRAME);
                                    if (state_next == S_FRAME) byte_counter_next = idx_next;
                                end else begin
                                    bit_cnt_next = bit_cnt_reg + 3'd1;
                                    shift_next   = {shift_reg[6:0], 1'b0};
                                    mosi_next    = shift_reg[6];
                                end
                            end
                        end else begin
                            div_cnt_next = div_cnt_reg + 1'b1;
                        end
                    end
                endcase
            end
        endcase
    end

    assign byte_counter = byte_counter_reg;
    assign oled_sclk    = sclk_reg;
    assign oled_mosi    = mosi_reg;
    assign oled_cs_n    = cs_n_reg;
    assign oled_dc      = dc_reg;
    assign oled_rst_n   = panel_rst_n_reg;
    assign init_done    = init_done_reg;
    assign frame_done   = frame_done_reg;
endmodule

// File: tb/tb_oled_frame_streamer.sv
// Bench for oled_frame_streamer: unit A (CLK_DIV=2) covers reset timing, init/address decode and
// mid-frame reset; unit B (CLK_DIV=1) streams two full frames and checks frame_done spacing.
module tb_oled_frame_streamer;
    logic       clk;
    logic       rst_n_a, rst_n_b;
    logic [7:0] data_a, data_b;
    logic [9:0] bc_a, bc_b;
    logic       sclk_a, mosi_a, cs_n_a, dc_a, orst_a, idone_a, fd_a;
    logic       sclk_b, mosi_b, cs_n_b, dc_b, orst_b, idone_b, fd_b;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    int nb_a  = 0;
    int nb_b  = 0;
    int fd_cnt_b = 0;

    logic [7:0] init_rom [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                                  8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                                  8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0] addr_rom [6]  = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    oled_frame_streamer #(.CLK_DIV(2), .RESET_CYCLES(10), .POWERUP_CYCLES(10)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .data_to_send(data_a), .byte_counter(bc_a),
        .oled_sclk(sclk_a), .oled_mosi(mosi_a), .oled_cs_n(cs_n_a), .oled_dc(dc_a),
        .oled_rst_n(orst_a), .init_done(idone_a), .frame_done(fd_a));

    oled_frame_streamer #(.CLK_DIV(1), .RESET_CYCLES(10), .POWERUP_CYCLES(10)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .data_to_send(data_b), .byte_counter(bc_b),
        .oled_sclk(sclk_b), .oled_mosi(mosi_b), .oled_cs_n(cs_n_b), .oled_dc(dc_b),
        .oled_rst_n(orst_b), .init_done(idone_b), .frame_done(fd_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Byte source: returns byte_counter[7:0] one clk later.
    always @(posedge clk) begin
        data_a <= bc_a[7:0];
        data_b <= bc_b[7:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected {dc, byte} of the n-th byte shifted out after reset.
    function automatic logic [8:0] exp_byte(input int n);
        int p;
        if (n < 25) return {1'b0, init_rom[n]};
        p = (n - 25) % 1030;
        if (p < 6) return {1'b0, addr_rom[p]};
        return {1'b1, 8'((p - 6) & 255)};
    endfunction

    function automatic int exp_bc(input int n);
        return ((n - 25) % 1030) - 6;
    endfunction

    // SPI decoder for unit A (CLK_DIV=2: 4 clks/bit, 34 clks/byte).
    initial begin
        int bits, last_start, last_rise;
        logic sclk_p, mosi_p;
        logic [7:0] sh;
        logic [8:0] e;
        bits = 0; last_start = -1; last_rise = 0; sclk_p = 1'b0; mosi_p = 1'b0; sh = '0;
        forever begin
            @(negedge clk);
            if (!rst_n_a) begin
                nb_a = 0; bits = 0; last_start = -1; sclk_p = 1'b0; mosi_p = 1'b0;
            end else begin
                if (!sclk_p && sclk_a) begin
                    if (bits == 0) begin
                        if (last_start >= 0) check("a_byte_clks", cyc - last_start, 34);
                        last_start = cyc;
                    end else begin
                        check("a_bit_clks", cyc - last_rise, 4);
                    end
                    last_rise = cyc;
                    sh = {sh[6:0], mosi_a};
                    bits++;
                    if (bits == 8) begin
                        bits = 0;
                        e = exp_byte(nb_a);
                        check("a_byte", {23'd0, dc_a, sh}, {23'd0, e});
                        if (e[8]) check("a_bc_match", 32'(bc_a), exp_bc(nb_a));
                        if (nb_a == 24) check("a_init_done_pre", 32'(idone_a), 32'd0);
                        if (nb_a == 25) check("a_init_done_post", 32'(idone_a), 32'd1);
                        $display("A byte %0d dc=%0b data=%02h bc=%0d", nb_a, dc_a, sh, bc_a);
                        nb_a++;
                    end
                end
                if (sclk_p && sclk_a) check("a_mosi_hold", 32'(mosi_a), 32'(mosi_p));
                sclk_p = sclk_a;
                mosi_p = mosi_a;
            end
        end
    end

    // SPI decoder and frame_done monitor for unit B (CLK_DIV=1: 2 clks/bit, 18 clks/byte).
    initial begin
        int bits, last_start, last_rise, last_fd;
        logic sclk_p, fd_p;
        logic [7:0] sh;
        logic [8:0] e;
        bits = 0; last_start = -1; last_rise = 0; last_fd = -1; sclk_p = 1'b0; fd_p = 1'b0; sh = '0;
        forever begin
            @(negedge clk);
            if (!rst_n_b) begin
                nb_b = 0; bits = 0; last_start = -1; sclk_p = 1'b0; fd_p = 1'b0;
            end else begin
                if (!sclk_p && sclk_b) begin
                    if (bits == 0) begin
                        if (last_start >= 0) check("b_byte_clks", cyc - last_start, 18);
                        last_start = cyc;
                    end else begin
                        check("b_bit_clks", cyc - last_rise, 2);
                    end
                    last_rise = cyc;
                    sh = {sh[6:0], mosi_b};
                    bits++;
                    if (bits == 8) begin
                        bits = 0;
                        e = exp_byte(nb_b);
                        check("b_byte", {23'd0, dc_b, sh}, {23'd0, e});
                        if (e[8]) check("b_bc_match", 32'(bc_b), exp_bc(nb_b));
                        if (nb_b == 24) check("b_init_done_pre", 32'(idone_b), 32'd0);
                        if (nb_b == 25) check("b_init_done_post", 32'(idone_b), 32'd1);
                        if (nb_b < 40 || (nb_b % 256) == 0)
                            $display("B byte %0d dc=%0b data=%02h bc=%0d", nb_b, dc_b, sh, bc_b);
                        nb_b++;
                    end
                end
                if (fd_p) check("b_fd_one_clk", 32'(fd_b), 32'd0);
                if (fd_b && !fd_p) begin
                    check("b_fd_bc", 32'(bc_b), 32'd1023);
                    check("b_fd_nbytes", nb_b, 1055 + 1030 * fd_cnt_b);
                    if (last_fd >= 0) check("b_fd_spacing", cyc - last_fd, 1030 * 18);
                    last_fd = cyc;
                    fd_cnt_b++;
                    $display("B frame_done %0d at cycle %0d", fd_cnt_b, cyc);
                end
                sclk_p = sclk_b;
                fd_p   = fd_b;
            end
        end
    end

    task automatic check_reset_a(input string tag);
        check({tag, "_sclk"}, 32'(sclk_a), 32'd0);
        check({tag, "_mosi"}, 32'(mosi_a), 32'd0);
        check({tag, "_cs_n"}, 32'(cs_n_a), 32'd1);
        check({tag, "_dc"},   32'(dc_a),   32'd0);
        check({tag, "_orst"}, 32'(orst_a), 32'd0);
        check({tag, "_bc"},   32'(bc_a),   32'd0);
        check({tag, "_idone"},32'(idone_a),32'd0);
        check({tag, "_fd"},   32'(fd_a),   32'd0);
    endtask

    initial begin
        int i;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_a("rst0");
        check("rst0_b_cs_n", 32'(cs_n_b), 32'd1);

        // Release; panel reset lifts after 10 clks, chip select after 20.
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("a_orst_at9", 32'(orst_a), 32'd0);
        @(negedge clk);
        check("a_orst_at10", 32'(orst_a), 32'd1);
        check("b_orst_at10", 32'(orst_b), 32'd1);
        repeat (9) @(negedge clk);
        check("a_cs_n_at19", 32'(cs_n_a), 32'd1);
        @(negedge clk);
        check("a_cs_n_at20", 32'(cs_n_a), 32'd0);
        $display("reset/powerup timing checked at cycle %0d", cyc);

        // Reach byte 500 of the first frame on unit A, then reset it mid-byte.
        for (i = 0; i < 40000 && bc_a != 10'd500; i++) @(negedge clk);
        check("a_reach_500", 32'(bc_a), 32'd500);
        repeat (7) @(negedge clk);
        check("a_nbytes_500", nb_a, 531);
        #2 rst_n_a = 1'b0;
        #1 check_reset_a("midrst");
        $display("mid-frame reset applied at cycle %0d", cyc);
        repeat (3) @(negedge clk);
        check("midrst_hold_orst", 32'(orst_a), 32'd0);
        rst_n_a = 1'b1;
        repeat (15) @(negedge clk);
        check("restart_cs_n_hi", 32'(cs_n_a), 32'd1);
        check("restart_idone_lo", 32'(idone_a), 32'd0);
        for (i = 0; i < 3000 && !idone_a; i++) @(negedge clk);
        check("restart_init_done", 32'(idone_a), 32'd1);
        check("restart_nbytes", nb_a, 25);
        repeat (40 * 34) @(negedge clk);

        // Two full frames on unit B.
        for (i = 0; i < 60000 && fd_cnt_b < 2; i++) @(negedge clk);
        check("b_frames", fd_cnt_b, 2);
        check("b_nbytes_end", 32'(nb_b >= 2085), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
